lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be: DM_ADDRESS, default 9, data-memory byte-address width; DATA_W, default 32, data width.
REQ-002 Clock and reset SHALL be: clk; reset. There is one clock, and reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  EX stage presents a memory request.
REQ-006 req_ready  out  1  block accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  instruction bits 14:12.
REQ-009 req_addr  in  DM_ADDRESS  byte address.
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 req_rd  in  5  destination-register tag, carried through unchanged.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  writeback accepts the response.
REQ-014 rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
REQ-015 rsp_rd  out  5  tag of the request being answered.
REQ-016 rsp_err  out  1  misaligned or illegal access; no memory access occurred.
REQ-017 MemRead, MemWrite  out  1 each  strobes to the data memory.
REQ-018 a  out  DM_ADDRESS  memory address.
REQ-019 wd  out  DATA_W  memory write data.
REQ-020 Funct3  out  3  funct3 passed to the memory.
REQ-021 mem_rdata  in  DATA_W  memory read data (rd).

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-023 req_ready SHALL be 1 exactly when the state is IDLE; a request is accepted when req_valid && req_ready.
REQ-024 On acceptance, the block SHALL register we, funct3, addr, wdata and rd.
REQ-025 On acceptance, the FSM SHALL go IDLE->ACCESS if the request is legal, or IDLE->RESP with the error flag set if it is not.
REQ-026 The following SHALL be illegal: load funct3 in {011,110,111}; store funct3 > 010; LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00.
REQ-027 In ACCESS, exactly one of MemRead/MemWrite SHALL be 1, for exactly one cycle, with a/wd/Funct3 driven from the registered request. Then ACCESS->RESP unconditionally.
REQ-028 A load SHALL capture mem_rdata at the end of the ACCESS cycle; mem_rdata is used unmodified because the memory already sign- or zero-extends.
REQ-029 In RESP, rsp_valid SHALL be 1, and rsp_rdata, rsp_rd and rsp_err SHALL be held stable until rsp_ready=1. Then RESP->IDLE.
REQ-030 Latency SHALL be: legal request accepted in cycle N -> strobe in N+1 -> rsp_valid in N+2. An illegal request gives rsp_valid in N+1.
REQ-031 Peak throughput SHALL be one request per 3 cycles; back-to-back acceptance is allowed in the cycle after RESP exits.
REQ-032 Stores SHALL produce a response with rsp_rdata=0 so that writeback retires in order.
REQ-033 MemRead and MemWrite SHALL never be 1 in the same cycle, and SHALL both be 0 outside ACCESS.
REQ-034 Outside ACCESS, a, wd and Funct3 SHALL be 0.
REQ-035 rsp_ready held 0 SHALL stall indefinitely, with no further memory strobes.

Reset
REQ-036 Assertion of reset SHALL immediately force: state IDLE; MemRead=MemWrite=0; rsp_valid=0; rsp_rdata=0; rsp_rd=0; rsp_err=0; all captured request fields 0; req_ready=1.
REQ-037 Reset asserted during ACCESS SHALL drop the strobe in the same cycle. The transaction is discarded and no response is ever issued.
REQ-038 Requests presented while reset is high SHALL be ignored.

Structure
REQ-039 The shared package lsu_pkg SHALL hold: the state enum (IDLE, ACCESS, RESP); funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU; the tag width constant 5.
REQ-040 One combinational sub-module, lsu_align_check (inputs we, funct3, addr[1:0]; output illegal), SHALL implement REQ-026.

Verification
REQ-041 The bench SHALL cover: LW at addr 0x010 when mem_rdata=0xDEADBEEF -> MemRead high only in N+1; rsp_valid in N+2 with rsp_rdata=0xDEADBEEF.
REQ-042 The bench SHALL cover: SB at addr 0x013 with wdata 0x000000AB -> MemWrite one cycle with a=0x013, Funct3=000; response rsp_rdata=0, rsp_err=0.
REQ-043 The bench SHALL cover: LW at addr 0x012 -> no MemRead ever; rsp_valid in N+1 with rsp_err=1.
REQ-044 The bench SHALL cover: store with funct3=011 -> rsp_err=1 and no MemWrite.
REQ-045 The bench SHALL cover: load response with rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, no strobes; release -> IDLE next cycle.
REQ-046 The bench SHALL cover: reset asserted in the ACCESS cycle of a SW -> MemWrite falls immediately, no response, and req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store control slice.
//   - state_t : controller states IDLE, ACCESS, RESP
//   - F3_*    : funct3 encodings of the supported load/store widths
//   - TAG_W   : width of the destination-register tag
package lsu_pkg;

    localparam int TAG_W = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: combinational legality check for one load/store request.
// Ports:
//   we      in  1 = store, 0 = load
//   funct3  in  access width / signedness encoding
//   addr    in  low two bits of the byte address
//   illegal out 1 when funct3 is unsupported for the direction or the
//               address is misaligned for the access width
module lsu_align_check
    import lsu_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        if (we) begin
            // Stores have no unsigned variants: only SB/SH/SW exist.
            case (funct3)
                F3_B:    illegal = 1'b0;
                F3_H:    illegal = addr[0];
                F3_W:    illegal = |addr;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B, F3_BU: illegal = 1'b0;
                F3_H, F3_HU: illegal = addr[0];
                F3_W:        illegal = |addr;
                default:     illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the EX stage,
// the data memory and writeback.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_funct3         direction and width of the access
//   req_addr, req_wdata        byte address and store data
//   req_rd                     destination tag, returned on rsp_rd
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_rd, rsp_err load result (0 for stores/errors), tag, error
//   MemRead, MemWrite          one-cycle memory strobes (ACCESS only)
//   a, wd, Funct3              memory address/write data/funct3 (0 outside ACCESS)
//   mem_rdata                  memory read data, already extended by the memory
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [TAG_W-1:0]      req_rd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [TAG_W-1:0]      rsp_rd,
    output logic                  rsp_err,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t                  state;
    logic                    illegal;
    logic                    accept;
    logic                    in_access;

    logic                    we_p1;
    logic [2:0]              funct3_p1;
    logic [DM_ADDRESS-1:0]   addr_p1;
    logic [DATA_W-1:0]       wdata_p1;
    logic [TAG_W-1:0]        rd_p1;
    logic                    err_p1;
    logic [DATA_W-1:0]       rdata_p2;

    lsu_align_check u_align (
        .we      (req_we),
        .funct3  (req_funct3),
        .addr    (req_addr[1:0]),
        .illegal (illegal)
    );

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_access = (state == ACCESS);

    // Stage p1: request captured on acceptance; illegal requests skip ACCESS.
    // Stage p2: load data captured at the end of ACCESS. rdata_p2 is cleared
    // on every acceptance so stores and errors answer with zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            we_p1     <= 1'b0;
            funct3_p1 <= '0;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            rd_p1     <= '0;
            err_p1    <= 1'b0;
            rdata_p2  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_p1     <= req_we;
                        funct3_p1 <= req_funct3;
                        addr_p1   <= req_addr;
                        wdata_p1  <= req_wdata;
                        rd_p1     <= req_rd;
                        err_p1    <= illegal;
                        rdata_p2  <= '0;
                        state     <= illegal ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_p1) begin
                        rdata_p2 <= mem_rdata;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode straight from state, so an asynchronous
    // reset during ACCESS drops the strobe without waiting for a clock edge.
    assign MemRead  = in_access && !we_p1;
    assign MemWrite = in_access &&  we_p1;
    assign a        = in_access ? addr_p1   : '0;
    assign wd       = in_access ? wdata_p1  : '0;
    assign Funct3   = in_access ? funct3_p1 : '0;

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_p2;
    assign rsp_rd    = rd_p1;
    assign rsp_err   = err_p1;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl. Expected responses
// are queued when a request is driven and popped when the response appears.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet_mem(input string tag);
        chk({tag, ":strobes"}, {MemRead, MemWrite}, 2'b00);
        chk({tag, ":a_wd_f3"}, {a, wd, Funct3}, 44'd0);
    endtask

    // One complete request/response exchange starting in IDLE.
    task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic legal,
                           input logic [31:0] mval, input int stall);
        rsp_t e;
        rsp_t x;
        chk({tag, ":ready_N"}, req_ready, 1'b1);
        chk({tag, ":no_strobe_N"}, {MemRead, MemWrite}, 2'b00);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        mem_rdata  = mval;
        e.rdata = (legal && !we) ? mval : 32'd0;
        e.rd    = rd;
        e.err   = !legal;
        sb.push_back(e);
        cycle();
        // Scramble request inputs; they must no longer matter.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 9'($urandom);
        req_wdata  = $urandom;
        req_rd     = 5'($urandom);
        if (legal) begin
            chk({tag, ":MemRead_N1"}, MemRead, !we);
            chk({tag, ":MemWrite_N1"}, MemWrite, we);
            chk({tag, ":a_N1"}, a, addr);
            chk({tag, ":wd_N1"}, wd, wdata);
            chk({tag, ":Funct3_N1"}, Funct3, f3);
            chk({tag, ":rsp_valid_N1"}, rsp_valid, 1'b0);
            chk({tag, ":ready_N1"}, req_ready, 1'b0);
            cycle();
            mem_rdata = $urandom;
        end
        chk({tag, ":rsp_valid"}, rsp_valid, 1'b1);
        if (sb.size() == 0) begin
            chk({tag, ":sb_empty"}, 1'b1, 1'b0);
            return;
        end
        x = sb.pop_front();
        for (int i = 0; i <= stall; i++) begin
            chk({tag, ":rsp_rdata"}, rsp_rdata, x.rdata);
            chk({tag, ":rsp_rd"}, rsp_rd, x.rd);
            chk({tag, ":rsp_err"}, rsp_err, x.err);
            chk({tag, ":rsp_hold_valid"}, rsp_valid, 1'b1);
            chk({tag, ":ready_resp"}, req_ready, 1'b0);
            chk_quiet_mem({tag, ":resp"});
            if (i < stall) cycle();
        end
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        chk({tag, ":rsp_valid_after"}, rsp_valid, 1'b0);
        chk({tag, ":ready_after"}, req_ready, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 9'd0;
        req_wdata  = 32'd0;
        req_rd     = 5'd0;
        rsp_ready  = 1'b0;
        mem_rdata  = 32'd0;
        #2;
        chk("rst:ready", req_ready, 1'b1);
        chk("rst:rsp_valid", rsp_valid, 1'b0);
        chk("rst:rsp_fields", {rsp_rdata, rsp_rd, rsp_err}, 38'd0);
        chk_quiet_mem("rst");
        cycle();
        cycle();
        reset = 1'b0;

        run_txn("lw_010",   1'b0, F3_W,    9'h010, 32'h0,        5'd3,  1'b1, 32'hDEADBEEF, 0);
        run_txn("sb_013",   1'b1, F3_B,    9'h013, 32'h000000AB, 5'd4,  1'b1, 32'h5555AAAA, 0);
        run_txn("lw_012",   1'b0, F3_W,    9'h012, 32'h0,        5'd5,  1'b0, 32'h11112222, 0);
        run_txn("st_f3_3",  1'b1, 3'b011,  9'h010, 32'hCAFE0001, 5'd6,  1'b0, 32'h33334444, 0);
        run_txn("lw_stall", 1'b0, F3_W,    9'h004, 32'h0,        5'd9,  1'b1, 32'hCAFEF00D, 5);
        run_txn("lhu_006",  1'b0, F3_HU,   9'h006, 32'h0,        5'd10, 1'b1, 32'h0000BEEF, 0);
        run_txn("lh_007",   1'b0, F3_H,    9'h007, 32'h0,        5'd11, 1'b0, 32'h77778888, 0);
        run_txn("ld_f3_6",  1'b0, 3'b110,  9'h008, 32'h0,        5'd12, 1'b0, 32'h9999AAAA, 0);
        run_txn("sh_002",   1'b1, F3_H,    9'h002, 32'h0000BEEF, 5'd13, 1'b1, 32'h0,        0);
        run_txn("sh_003",   1'b1, F3_H,    9'h003, 32'h0000BEEF, 5'd14, 1'b0, 32'h0,        0);
        run_txn("sw_00c",   1'b1, F3_W,    9'h00C, 32'h01234567, 5'd15, 1'b1, 32'h0,        1);
        run_txn("lb_1ff",   1'b0, F3_BU,   9'h1FF, 32'h0,        5'd31, 1'b1, 32'h000000FF, 0);

        // Reset in the ACCESS cycle of a store.
        chk("rstacc:ready", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 9'h020;
        req_wdata  = 32'hA5A5A5A5;
        req_rd     = 5'd7;
        cycle();
        req_valid = 1'b0;
        chk("rstacc:MemWrite_on", MemWrite, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstacc:MemWrite_off", MemWrite, 1'b0);
        chk("rstacc:ready", req_ready, 1'b1);
        chk("rstacc:rsp_valid", rsp_valid, 1'b0);
        chk("rstacc:rsp_fields", {rsp_rdata, rsp_rd, rsp_err}, 38'd0);
        chk_quiet_mem("rstacc");
        // Requests during reset are ignored.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 9'h000;
        cycle();
        cycle();
        chk("rstreq:ready", req_ready, 1'b1);
        chk_quiet_mem("rstreq");
        req_valid = 1'b0;
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("post_rst:rsp_valid", rsp_valid, 1'b0);
            chk_quiet_mem("post_rst");
        end
        rsp_ready = 1'b0;

        run_txn("lw_recov", 1'b0, F3_W, 9'h040, 32'h0, 5'd1, 1'b1, 32'h600DF00D, 0);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
